tetron_collision_checker: RTL
=============================

# tetron_collision_checker

Sequential collision checker that sits directly downstream of the tetron shapers. On a `start` pulse it latches the piece anchor and the four block offsets produced by the active shaper. It then walks the four blocks, bounds-checking each and reading the board occupancy memory one cell per block. It reports a single `collision` verdict with a `done` pulse, which the game controller uses to accept or reject a move, drop or rotation.

## Interface

Parameters:
- `BOARD_W`, default 10: playfield width in cells.
- `BOARD_H`, default 20: playfield height in cells.
- `ADDR_W`, default 8: board memory address width; must satisfy 2^ADDR_W ≥ BOARD_W·BOARD_H.

Ports:
- `clk` input 1: system clock; all state changes on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle request; sampled only in IDLE.
- `piece_row` input 5: anchor row (0 = top).
- `piece_col` input 5: anchor column (0 = left).
- `blk1_voffset` … `blk4_voffset` input 5 each: shaper row offsets.
- `blk1_hoffset` … `blk4_hoffset` input 5 each: shaper column offsets.
- `board_rd_en` output 1: board read strobe.
- `board_addr` output ADDR_W: cell address, computed as row·BOARD_W + col.
- `board_rd_data` input 1: occupancy bit, valid exactly one cycle after `board_rd_en`.
- `busy` output 1: high from the cycle after an accepted `start` through the DONE cycle.
- `done` output 1: one-cycle pulse when the verdict is valid.
- `collision` output 1: verdict; 1 = out of bounds or overlaps an occupied cell.

## Operation

- FSM states are IDLE, ISSUE, SAMPLE and DONE. A 2-bit block index `idx` runs 0..3.
- IDLE: `start`=1 latches `piece_row`, `piece_col` and all eight offsets into internal registers, clears `collision`, sets `idx`=0 and moves to ISSUE. Later input changes do not affect the running check.
- ISSUE:
  - Form `r = piece_row + voffset[idx]` and `c = piece_col + hoffset[idx]` in 6 bits, so no wrap is possible.
  - If r ≥ BOARD_H or c ≥ BOARD_W: set `collision`=1, keep `board_rd_en`=0, go to DONE.
  - Otherwise: drive `board_rd_en`=1 and `board_addr`=r·BOARD_W+c (truncated to ADDR_W), go to SAMPLE.
- SAMPLE:
  - If `board_rd_data`=1: set `collision`=1 and go to DONE (early exit).
  - Else if `idx`=3: go to DONE.
  - Else: increment `idx` and go to ISSUE.
- DONE: `done`=1 for exactly one cycle, then IDLE. `collision` holds its value until the next accepted `start`.
- `start` while `busy` is ignored; it is not queued.
- `board_addr` holds its last value when `board_rd_en`=0; consumers must not rely on it then.

## Timing

- Reset values: state IDLE, `idx`=0, `busy`=0, `done`=0, `collision`=0, `board_rd_en`=0, `board_addr`=0, latched registers 0.
- Cycle numbering: `start` sampled at edge 0. The first ISSUE cycle is cycle 1, and each block costs 2 cycles (ISSUE, SAMPLE).
- Latencies from the `start` edge to `done`:
  - Worst case, no collision: 9 cycles (ISSUE/SAMPLE on cycles 1–8, DONE on cycle 9).
  - Out of bounds at block k (k = 0..3): 2k+2 cycles.
  - Occupied cell at block k: 2k+3 cycles.
- `busy` is 1 on cycles 1 through the DONE cycle inclusive. It is 0 in IDLE, and a new `start` is accepted on the cycle after DONE.
- `board_rd_en`/`board_addr` are registered outputs valid in the ISSUE cycle; `board_rd_data` is sampled in the following SAMPLE cycle.
- Reset asserted mid-check: immediate return to IDLE with all outputs at reset values. No `done` is produced for the aborted check.
- Offsets of 0 for all blocks (inactive shaper) are legal; the check degenerates to four reads of the anchor cell.

## Test plan

- Empty board, anchor (0,0), O offsets {(0,0),(1,1),(0,1),(1,0)} → reads at addresses 0, 11, 1, 10; `done` 9 cycles after `start`; `collision`=0.
- Board cell 11 occupied, same piece → reads at 0 then 11 only; `done` at cycle 5; `collision`=1; no third `board_rd_en`.
- Anchor col 9 with block2 hoffset 1 (c=10) → block1 read at address 9; block2 flagged out of bounds without a read; `done` at cycle 4; `collision`=1.
- Anchor row 19 with voffset 1 (r=20) on block1, plus separate case anchor row 31, offset 31 (r=62, 6-bit, no wrap) → `collision`=1, `done` at cycle 2, `board_rd_en` never asserted.
- Second `start` pulsed on cycle 3 of a running check → ignored; exactly one `done`; `start` on the cycle after DONE → accepted with `collision` cleared.
- `rst` asserted on cycle 4 of a check → `busy`, `board_rd_en`, `collision` go 0 asynchronously; no `done`; a subsequent `start` runs a full 9-cycle check.

Source files
------------

// File: rtl/tetron_collision_checker.sv
// tetron_collision_checker
// Latches a tetron anchor and its four block offsets on start, then walks the
// blocks one at a time: bounds-check, read the board cell, and stop at the
// first block that is out of bounds or lands on an occupied cell. The verdict
// is presented on collision together with a one-cycle done pulse.
module tetron_collision_checker #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [4:0]        piece_row,
    input  logic [4:0]        piece_col,
    input  logic [4:0]        blk1_voffset,
    input  logic [4:0]        blk2_voffset,
    input  logic [4:0]        blk3_voffset,
    input  logic [4:0]        blk4_voffset,
    input  logic [4:0]        blk1_hoffset,
    input  logic [4:0]        blk2_hoffset,
    input  logic [4:0]        blk3_hoffset,
    input  logic [4:0]        blk4_hoffset,
    output logic              board_rd_en,
    output logic [ADDR_W-1:0] board_addr,
    input  logic              board_rd_data,
    output logic              busy,
    output logic              done,
    output logic              collision
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [5:0] H_LIMIT = 6'(BOARD_H);
    localparam logic [5:0] W_LIMIT = 6'(BOARD_W);

    logic [1:0]        r_state;
    logic [1:0]        r_idx;
    logic [4:0]        r_row;
    logic [4:0]        r_col;
    logic [4:0]        r_voff [4];
    logic [4:0]        r_hoff [4];
    logic              r_oob;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_addr;
    logic              r_collision;

    logic [1:0]        w_next_idx;
    logic [4:0]        w_sel_row;
    logic [4:0]        w_sel_col;
    logic [4:0]        w_sel_voff;
    logic [4:0]        w_sel_hoff;
    logic [5:0]        w_r;
    logic [5:0]        w_c;
    logic              w_oob;
    logic [ADDR_W-1:0] w_addr;

    assign w_next_idx = r_idx + 2'd1;

    // Pick the block that the next ISSUE cycle will examine, so its read strobe
    // and address can be registered on the way into ISSUE: the live inputs when
    // a check is being accepted, otherwise the latched copy of the next block.
    always_comb begin
        w_sel_row  = r_row;
        w_sel_col  = r_col;
        w_sel_voff = r_voff[w_next_idx];
        w_sel_hoff = r_hoff[w_next_idx];
        if (r_state == S_IDLE) begin
            w_sel_row  = piece_row;
            w_sel_col  = piece_col;
            w_sel_voff = blk1_voffset;
            w_sel_hoff = blk1_hoffset;
        end
    end

    // Six-bit sums cannot wrap, so a large offset always lands out of bounds.
    assign w_r    = {1'b0, w_sel_row} + {1'b0, w_sel_voff};
    assign w_c    = {1'b0, w_sel_col} + {1'b0, w_sel_hoff};
    assign w_oob  = (w_r >= H_LIMIT) || (w_c >= W_LIMIT);
    assign w_addr = ADDR_W'(16'(w_r) * 16'(BOARD_W) + 16'(w_c));

    // Sequencer: accept a request, then alternate ISSUE/SAMPLE per block until
    // a collision is found or all four blocks are clear.
    // NOTE: every register here uses <= so each branch reads the pre-edge
    // values of r_idx/r_state; blocking writes would leak into the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_idx       <= 2'd0;
            r_row       <= '0;
            r_col       <= '0;
            // NOTE: the offset file is only four entries and its reset value is
            // part of the block's defined state, so it is cleared like any flop.
            for (int i = 0; i < 4; i++) begin
                r_voff[i] <= '0;
                r_hoff[i] <= '0;
            end
            r_oob       <= 1'b0;
            r_rd_en     <= 1'b0;
            r_addr      <= '0;
            r_collision <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_row       <= piece_row;
                        r_col       <= piece_col;
                        r_voff[0]   <= blk1_voffset;
                        r_voff[1]   <= blk2_voffset;
                        r_voff[2]   <= blk3_voffset;
                        r_voff[3]   <= blk4_voffset;
                        r_hoff[0]   <= blk1_hoffset;
                        r_hoff[1]   <= blk2_hoffset;
                        r_hoff[2]   <= blk3_hoffset;
                        r_hoff[3]   <= blk4_hoffset;
                        r_idx       <= 2'd0;
                        r_collision <= 1'b0;
                        r_oob       <= w_oob;
                        r_rd_en     <= !w_oob;
                        if (!w_oob) r_addr <= w_addr;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_rd_en <= 1'b0;
                    if (r_oob) begin
                        r_collision <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_state     <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    if (board_rd_data) begin
                        r_collision <= 1'b1;
                        r_state     <= S_DONE;
                    end else if (r_idx == 2'd3) begin
                        r_state     <= S_DONE;
                    end else begin
                        r_idx   <= w_next_idx;
                        r_oob   <= w_oob;
                        r_rd_en <= !w_oob;
                        if (!w_oob) r_addr <= w_addr;
                        r_state <= S_ISSUE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign board_rd_en = r_rd_en;
    assign board_addr  = r_addr;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign collision   = r_collision;

endmodule
